l2_mem_arbiter: RTL

//   Shares one single-port 64-bit L2 SRAM cut (CEN/WEN/A/D/BE/Q, active-low

---
 rtl/l2_mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one single-port 64-bit L2 SRAM between N_PORTS requesters.
// Grant and SRAM controls are combinational; the 1-cycle response is routed back to its issuer.
module l2_mem_arbiter #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic [N_PORTS-1:0]             req_i,
    input  logic [N_PORTS-1:0]             we_i,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [N_PORTS*64-1:0]          wdata_i,
    input  logic [N_PORTS*8-1:0]           be_i,
    output logic [N_PORTS-1:0]             gnt_o,
    output logic [N_PORTS-1:0]             r_valid_o,
    output logic [63:0]                    r_rdata_o,
    output logic                           CEN,
    output logic                           WEN,
    output logic [ADDR_WIDTH-1:0]          A,
    output logic [63:0]                    D,
    output logic [7:0]                     BE,
    input  logic [63:0]                    Q
);

    localparam int unsigned PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;

    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_resp_vld;
    logic [PTR_W-1:0] r_resp_port;
    logic             r_resp_rd;

    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_win;
    logic             w_found;
    logic             w_grant;

    // Port index (base + off) wrapped into 0..N_PORTS-1.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        return PTR_W'(sum % N_PORTS);
    endfunction

    // First requester found when scanning from the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_idx = wrap_add(r_rr_ptr, i);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // No access may leave the arbiter while reset is held.
    assign w_grant = w_found & RSTN;

    always_comb begin
        gnt_o = '0;
        CEN   = 1'b1;
        WEN   = 1'b1;
        A     = '0;
        D     = '0;
        BE    = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (w_grant && (w_win == PTR_W'(k))) begin
                gnt_o[k] = 1'b1;
                CEN      = 1'b0;
                WEN      = ~we_i[k];
                A        = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                D        = wdata_i[k*DATA_W +: DATA_W];
                BE       = be_i[k*BE_W +: BE_W];
            end
        end
    end

    // Pointer advance and response tracking; reset drops any in-flight response.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_rr_ptr    <= '0;
            r_resp_vld  <= 1'b0;
            r_resp_port <= '0;
            r_resp_rd   <= 1'b0;
        end else begin
            r_resp_vld <= w_grant;
            r_resp_rd  <= w_grant & ~we_i[w_win];
            if (w_grant) begin
                r_rr_ptr    <= wrap_add(w_win, 32'd1);
                r_resp_port <= w_win;
            end
        end
    end

    always_comb begin
        r_valid_o = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (r_resp_vld && (r_resp_port == PTR_W'(k))) begin
                r_valid_o[k] = 1'b1;
            end
        end
    end

    assign r_rdata_o = r_resp_rd ? Q : '0;

endmodule
